amplitude_prune_serializer: RTL
===============================

// Module: amplitude_prune_serializer
// PURPOSE
// - Downstream of the amplitude pair multiply-add stage. Accepts one pair of updated
//   amplitudes (amp1', amp2') per handshake, each with its basis-state tag.
// - Serializes the pair into a one-amplitude-per-beat stream for the state-vector
//   write-back, drops zero amplitudes and counts the survivors of each frame.
// PARAMETERS
// - complex_bit  24  width of each signed real/imag half; one amplitude = 2*complex_bit
// - tag_bit      8   basis-state tag width
// - count_bit    9   survivor counter width; counter saturates
// PORTS
// - clk             in   1              clock
// - rst_n           in   1              asynchronous reset, active low
// - in_valid        in   1              pair valid
// - in_ready        out  1              pair accepted when in_valid & in_ready
// - in_pair         in   1              1: amp1 and amp2 valid; 0: only amp1 valid
// - in_last         in   1              last pair of the frame
// - in_amp1/in_amp2 in   2*complex_bit  {real,imag} amplitudes (mult-add outputs 1/2)
// - in_tag1/in_tag2 in   tag_bit        basis tags for amp1/amp2
// - out_valid       out  1              output beat valid
// - out_ready       in   1              downstream ready
// - out_amp         out  2*complex_bit  amplitude
// - out_tag         out  tag_bit        tag
// - out_last        out  1              final beat emitted from the in_last pair
// - survivor_count  out  count_bit      beats emitted in the current/last frame
// - frame_done      out  1              one-cycle pulse at end of frame
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_amp=0, out_tag=0,
//   out_last=0, survivor_count=0, frame_done=0; any held pair is discarded.
// - keepN = entry valid & (amp != 0, whole 2*complex_bit word) [zero test per CONFIGURATION].
//   keep2 forced 0 when in_pair=0.
// - FSM: IDLE, EMIT1, EMIT2. On accept, pair, tags and last are registered; next state:
//   keep1 -> EMIT1; else keep2 -> EMIT2; else IDLE (pair dropped, no beat emitted).
// - EMIT1 presents amp1/tag1; on out handshake: keep2 -> EMIT2, else IDLE.
//   EMIT2 presents amp2/tag2; on out handshake -> IDLE.
// - out_valid=1 exactly in EMIT1/EMIT2; outputs are registered and stable while
//   out_valid & !out_ready.
// - Latency: accept in cycle N -> first beat valid in N+1.
// - in_ready = IDLE | (out_valid & out_ready & final beat of held pair). Final beat is
//   EMIT2, or EMIT1 with keep2=0. A new pair may be accepted in the same cycle
//   (back-to-back, 1 beat/cycle sustained).
// - out_last = held last & final beat. If both entries of the last pair are pruned,
//   no beat carries out_last; frame_done still fires.
// - survivor_count increments on each out handshake and saturates at 2^count_bit-1.
//   It holds after frame_done, clears to 0 on the first accept of the next frame,
//   and increments on that first accept's later beats.
// - frame_done pulses the cycle after the final beat handshake of an in_last pair,
//   or the cycle after accepting an in_last pair with nothing kept.
// - Arithmetic: none on amplitudes; data passes bit-exact.
// CONFIGURATION
// - PRUNE_ZERO_EN defined: zero amplitudes are dropped as above.
// - PRUNE_ZERO_EN undefined: keepN = entry valid only. Every valid entry is emitted,
//   including zeros; survivor_count = valid entries.
// TESTING
// - Pair (0x000001_000000, 0x000000_FFFFFF), in_pair=1, out_ready=1 -> two beats in
//   cycles N+1, N+2 with tags 1,2; survivor_count=2.
// - amp1=0, amp2=0x000010_000000, PRUNE_ZERO_EN -> single beat with tag2, in_ready high
//   during its handshake; without macro -> two beats.
// - Hold out_ready=0 for 5 cycles in EMIT1 -> out_amp/out_tag stable, in_ready=0,
//   no beat lost after release.
// - Frame of 3 pairs, last pair both zero (pruned) -> no out_last;
//   frame_done 1 cycle after accept of pair 3; survivor_count=4 held.
// - in_pair=0, in_last=1, amp1 nonzero -> one beat with out_last=1, frame_done next cycle.
// - rst_n low while in EMIT2 -> out_valid=0 immediately, counter 0, in_ready=1.

Source files
------------

// File: rtl/amplitude_prune_serializer.sv
// -----------------------------------------------------------------------------
// amplitude_prune_serializer
//
// Sits after the amplitude pair multiply-add stage. Each accepted pair of
// updated amplitudes (amp1', amp2') is turned into a one-amplitude-per-beat
// stream for the state-vector write-back. Zero amplitudes may be pruned, and
// the beats that survive are counted for each frame.
//
// Optional feature macro: PRUNE_ZERO_EN
//   defined   -> an amplitude whose whole {real,imag} word is zero is dropped
//   undefined -> every valid entry is emitted, zeros included
//
// Parameters
//   complex_bit : width of each signed real/imag half (amplitude = 2*complex_bit)
//   tag_bit     : basis-state tag width
//   count_bit   : survivor counter width (saturating)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               pair handshake
//   in_pair                         1: amp1 and amp2 valid, 0: only amp1 valid
//   in_last                         last pair of the frame
//   in_amp1/in_amp2, in_tag1/in_tag2 amplitudes and their basis tags
//   out_valid/out_ready             beat handshake
//   out_amp, out_tag, out_last      beat payload; out_last marks the frame's final beat
//   survivor_count                  beats emitted in the current/last frame
//   frame_done                      one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module amplitude_prune_serializer #(
  parameter int complex_bit = 24,
  parameter int tag_bit     = 8,
  parameter int count_bit   = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_pair,
  input  logic                     in_last,
  input  logic [2*complex_bit-1:0] in_amp1,
  input  logic [2*complex_bit-1:0] in_amp2,
  input  logic [tag_bit-1:0]       in_tag1,
  input  logic [tag_bit-1:0]       in_tag2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*complex_bit-1:0] out_amp,
  output logic [tag_bit-1:0]       out_tag,
  output logic                     out_last,
  output logic [count_bit-1:0]     survivor_count,
  output logic                     frame_done
);

  localparam int amp_bit = 2 * complex_bit;

`ifdef PRUNE_ZERO_EN
  localparam logic prune_en = 1'b1;
`else
  localparam logic prune_en = 1'b0;
`endif

  localparam logic [count_bit-1:0] count_max = {count_bit{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  // An entry survives when it is valid and, with pruning on, its whole word is nonzero.
  function automatic logic entry_kept(input logic entry_valid,
                                      input logic [amp_bit-1:0] amp);
    return entry_valid & (~prune_en | (|amp));
  endfunction

  state_t               state_r;
  logic [amp_bit-1:0]   amp2_r;
  logic [tag_bit-1:0]   tag2_r;
  logic                 keep2_r;
  logic                 last_r;
  logic                 new_frame_r;
  logic                 out_valid_r;
  logic [amp_bit-1:0]   out_amp_r;
  logic [tag_bit-1:0]   out_tag_r;
  logic                 out_last_r;
  logic [count_bit-1:0] count_r;
  logic                 frame_done_r;

  logic keep1_s;
  logic keep2_s;
  logic out_hs_s;
  logic final_beat_s;
  logic in_ready_s;
  logic accept_s;
  logic drop_last_s;
  logic last_beat_end_s;
  logic frame_end_s;
  logic new_frame_s;

  // Handshake decode, final-beat detection and frame boundary detection.
  always_comb begin
    keep1_s      = entry_kept(1'b1, in_amp1);
    keep2_s      = entry_kept(in_pair, in_amp2);
    out_hs_s     = out_valid_r & out_ready;
    final_beat_s = 1'b0;
    case (state_r)
      EMIT1:   final_beat_s = ~keep2_r;
      EMIT2:   final_beat_s = 1'b1;
      default: final_beat_s = 1'b0;
    endcase
    // A new pair can be taken while the held pair's final beat leaves.
    in_ready_s      = (state_r == IDLE) | (out_hs_s & final_beat_s);
    accept_s        = in_valid & in_ready_s;
    drop_last_s     = accept_s & in_last & ~keep1_s & ~keep2_s;
    last_beat_end_s = out_hs_s & final_beat_s & last_r;
    frame_end_s     = last_beat_end_s | drop_last_s;
    // The accept that coincides with the previous frame's final beat opens a new frame.
    new_frame_s     = new_frame_r | last_beat_end_s;
  end

  // Serializer FSM, output payload registers, survivor counter and frame tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      amp2_r       <= {amp_bit{1'b0}};
      tag2_r       <= {tag_bit{1'b0}};
      keep2_r      <= 1'b0;
      last_r       <= 1'b0;
      new_frame_r  <= 1'b1;
      out_valid_r  <= 1'b0;
      out_amp_r    <= {amp_bit{1'b0}};
      out_tag_r    <= {tag_bit{1'b0}};
      out_last_r   <= 1'b0;
      count_r      <= {count_bit{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;

      if (accept_s) begin
        amp2_r      <= in_amp2;
        tag2_r      <= in_tag2;
        keep2_r     <= keep2_s;
        last_r      <= in_last;
        out_valid_r <= keep1_s | keep2_s;
        // The first presented beat is final unless both entries survive.
        out_last_r  <= in_last & (keep1_s ^ keep2_s);
        if (keep1_s) begin
          state_r   <= EMIT1;
          out_amp_r <= in_amp1;
          out_tag_r <= in_tag1;
        end else if (keep2_s) begin
          state_r   <= EMIT2;
          out_amp_r <= in_amp2;
          out_tag_r <= in_tag2;
        end else begin
          state_r   <= IDLE;
        end
      end else if (out_hs_s) begin
        if ((state_r == EMIT1) && keep2_r) begin
          state_r    <= EMIT2;
          out_amp_r  <= amp2_r;
          out_tag_r  <= tag2_r;
          out_last_r <= last_r;
        end else begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      end

      if (accept_s && new_frame_s) begin
        count_r <= {count_bit{1'b0}};
      end else if (out_hs_s && (count_r != count_max)) begin
        count_r <= count_r + {{(count_bit-1){1'b0}}, 1'b1};
      end

      if (accept_s) begin
        new_frame_r <= drop_last_s;
      end else if (frame_end_s) begin
        new_frame_r <= 1'b1;
      end
    end
  end

  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_r;
  assign out_amp        = out_amp_r;
  assign out_tag        = out_tag_r;
  assign out_last       = out_last_r;
  assign survivor_count = count_r;
  assign frame_done     = frame_done_r;

endmodule
